skolem_sweep_checker: RTL

Sequential harness stage directly upstream of a combinational Skolem-function block. Exhaustively enumerates the universal input vector x, drives it into the Skolem block, and captures the witness output y. It forwards (x, y) to a formula evaluator and consumes the evaluator's verdict phi. It accumulates failures and records the first counterexample, so each synthesized Skolem netlist is certified in hardware.

---
 rtl/skolem_sweep_checker.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/skolem_sweep_checker.sv
// Exhaustive sweep harness for a combinational Skolem block: walks every x,
// waits out the evaluator latency, then tallies phi failures and the first counterexample.
module skolem_sweep_checker #(
   parameter int unsigned NX       = 8,
   parameter int unsigned NY       = 1,
   parameter int unsigned EVAL_LAT = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          abort,
   output logic [NX-1:0] x_out,
   input  logic [NY-1:0] y_in,
   input  logic          phi_in,
   output logic          busy,
   output logic          done,
   output logic          pass,
   output logic [NX:0]   fail_count,
   output logic          first_fail_valid,
   output logic [NX-1:0] first_fail_x,
   output logic [NY-1:0] first_fail_y
);

   localparam int unsigned CW = 4;
   localparam logic [CW-1:0] CNT_LOAD = CW'(EVAL_LAT - 1);
   localparam logic [NX-1:0] X_LAST   = '1;

   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;

   state_t        r_state,    w_nxt_state;
   logic [CW-1:0] r_cnt,      w_nxt_cnt;
   logic [NX-1:0] r_x,        w_nxt_x;
   logic          r_busy,     w_nxt_busy;
   logic          r_done,     w_nxt_done;
   logic [NX:0]   r_fail_cnt, w_nxt_fail_cnt;
   logic          r_ff_valid, w_nxt_ff_valid;
   logic [NX-1:0] r_ff_x,     w_nxt_ff_x;
   logic [NY-1:0] r_ff_y,     w_nxt_ff_y;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_x        <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_fail_cnt <= '0;
         r_ff_valid <= 1'b0;
         r_ff_x     <= '0;
         r_ff_y     <= '0;
      end else begin
         r_state    <= w_nxt_state;
         r_cnt      <= w_nxt_cnt;
         r_x        <= w_nxt_x;
         r_busy     <= w_nxt_busy;
         r_done     <= w_nxt_done;
         r_fail_cnt <= w_nxt_fail_cnt;
         r_ff_valid <= w_nxt_ff_valid;
         r_ff_x     <= w_nxt_ff_x;
         r_ff_y     <= w_nxt_ff_y;
      end
   end

   // Abort takes priority over sampling so partial results reflect only completed vectors.
   always_comb begin
      w_nxt_state    = r_state;
      w_nxt_cnt      = r_cnt;
      w_nxt_x        = r_x;
      w_nxt_busy     = r_busy;
      w_nxt_done     = r_done;
      w_nxt_fail_cnt = r_fail_cnt;
      w_nxt_ff_valid = r_ff_valid;
      w_nxt_ff_x     = r_ff_x;
      w_nxt_ff_y     = r_ff_y;

      case (r_state)
         S_IDLE, S_DONE: begin
            if (start) begin
               w_nxt_state    = S_SETTLE;
               w_nxt_cnt      = CNT_LOAD;
               w_nxt_x        = '0;
               w_nxt_busy     = 1'b1;
               w_nxt_done     = 1'b0;
               w_nxt_fail_cnt = '0;
               w_nxt_ff_valid = 1'b0;
               w_nxt_ff_x     = '0;
               w_nxt_ff_y     = '0;
            end
         end
         S_SETTLE: begin
            if (abort) begin
               w_nxt_state = S_IDLE;
               w_nxt_busy  = 1'b0;
               w_nxt_done  = 1'b0;
            end else if (r_cnt == '0) begin
               w_nxt_state = S_SAMPLE;
            end else begin
               w_nxt_cnt = r_cnt - CW'(1);
            end
         end
         S_SAMPLE: begin
            if (abort) begin
               w_nxt_state = S_IDLE;
               w_nxt_busy  = 1'b0;
               w_nxt_done  = 1'b0;
            end else begin
               if (!phi_in) begin
                  w_nxt_fail_cnt = r_fail_cnt + (NX+1)'(1);
                  if (!r_ff_valid) begin
                     w_nxt_ff_valid = 1'b1;
                     w_nxt_ff_x     = r_x;
                     w_nxt_ff_y     = y_in;
                  end
               end
               if (r_x == X_LAST) begin
                  w_nxt_state = S_DONE;
                  w_nxt_busy  = 1'b0;
                  w_nxt_done  = 1'b1;
               end else begin
                  w_nxt_state = S_SETTLE;
                  w_nxt_x     = r_x + NX'(1);
                  w_nxt_cnt   = CNT_LOAD;
               end
            end
         end
         default: begin
            w_nxt_state = S_IDLE;
         end
      endcase
   end

   assign x_out            = r_x;
   assign busy             = r_busy;
   assign done             = r_done;
   assign pass             = r_done && (r_fail_cnt == '0);
   assign fail_count       = r_fail_cnt;
   assign first_fail_valid = r_ff_valid;
   assign first_fail_x     = r_ff_x;
   assign first_fail_y     = r_ff_y;

endmodule
